// File: rtl/regfile_operand_fetch.sv
// Operand fetch controller: latches decoded instructions, reads the register file,
// holds operands for downstream and tracks pending writes. Optional: REGFILE_FETCH_FWD_BYPASS_EN.
module regfile_operand_fetch #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 3,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      issue_valid,
   output logic                      issue_ready,
   input  logic [BITS_ADDR-1:0]      issue_rs1,
   input  logic [BITS_ADDR-1:0]      issue_rs2,
   input  logic [BITS_ADDR-1:0]      issue_rd,
   input  logic                      issue_rd_we,
   output logic [BITS_ADDR-1:0]      rf_rd_addr1,
   output logic [BITS_ADDR-1:0]      rf_rd_addr2,
   input  logic [BITS_DATA-1:0]      rf_rd_data1,
   input  logic [BITS_DATA-1:0]      rf_rd_data2,
   output logic                      op_valid,
   input  logic                      op_ready,
   output logic [BITS_DATA-1:0]      op_a,
   output logic [BITS_DATA-1:0]      op_b,
   output logic [BITS_ADDR-1:0]      op_rd,
   output logic                      op_rd_we,
   input  logic                      wb_valid,
   input  logic [BITS_ADDR-1:0]      wb_addr,
   input  logic [BITS_DATA-1:0]      wb_data,
   output logic                      rf_we,
   output logic [BITS_ADDR-1:0]      rf_wr_addr,
   output logic [BITS_DATA-1:0]      rf_wr_data,
   output logic [(2**BITS_ADDR)-1:0] busy_mask,
   output logic [CNT_W-1:0]          stall_cycles,
   output logic                      wb_spurious
);
   localparam int NREGS = 2**BITS_ADDR;

   typedef enum logic [1:0] {IDLE, STALL, READ, HOLD} state_t;

   state_t               state_q, state_d;
   logic [BITS_ADDR-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic                 rd_we_q, rd_we_d;
   logic [BITS_DATA-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic [NREGS-1:0]     busy_q, busy_d, stall_mask;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
   logic                 rf_we_q, rf_we_d;
   logic [BITS_ADDR-1:0] rf_wr_addr_q, rf_wr_addr_d;
   logic [BITS_DATA-1:0] rf_wr_data_q, rf_wr_data_d;
   logic                 spurious_q, spurious_d;

`ifdef REGFILE_FETCH_FWD_BYPASS_EN
   // The write on the port lands at the same edge that would enter READ.
   logic [NREGS-1:0] wr_onehot;
   always_comb begin
      wr_onehot = '0;
      wr_onehot[rf_wr_addr_q] = rf_we_q;
      stall_mask = busy_q & ~wr_onehot;
   end
`else
   assign stall_mask = busy_q;
`endif

   always_comb begin
      state_d      = state_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      rd_we_d      = rd_we_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      stall_cnt_d  = stall_cnt_q;
      busy_d       = busy_q;
      rf_we_d      = wb_valid;
      rf_wr_addr_d = wb_valid ? wb_addr : rf_wr_addr_q;
      rf_wr_data_d = wb_valid ? wb_data : rf_wr_data_q;
      spurious_d   = spurious_q | (rf_we_q & ~busy_q[rf_wr_addr_q]);

      if (rf_we_q) busy_d[rf_wr_addr_q] = 1'b0;

      case (state_q)
         IDLE: if (issue_valid) begin
            rs1_d   = issue_rs1;
            rs2_d   = issue_rs2;
            rd_d    = issue_rd;
            rd_we_d = issue_rd_we;
            state_d = (busy_q[issue_rs1] | busy_q[issue_rs2]) ? STALL : READ;
         end
         STALL: begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (!(stall_mask[rs1_q] | stall_mask[rs2_q])) state_d = READ;
         end
         READ: begin
            op_a_d  = rf_rd_data1;
            op_b_d  = rf_rd_data2;
            // Applied after the clear so the newer writer stays pending.
            if (rd_we_q) busy_d[rd_q] = 1'b1;
            state_d = HOLD;
         end
         HOLD: if (op_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         rd_we_q      <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         busy_q       <= '0;
         stall_cnt_q  <= '0;
         rf_we_q      <= 1'b0;
         rf_wr_addr_q <= '0;
         rf_wr_data_q <= '0;
         spurious_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         rd_we_q      <= rd_we_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         busy_q       <= busy_d;
         stall_cnt_q  <= stall_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_wr_addr_q <= rf_wr_addr_d;
         rf_wr_data_q <= rf_wr_data_d;
         spurious_q   <= spurious_d;
      end
   end

   // Gated so every output reads 0 while reset is held.
   assign issue_ready  = (state_q == IDLE) && !reset;
   assign op_valid     = (state_q == HOLD);
   assign rf_rd_addr1  = rs1_q;
   assign rf_rd_addr2  = rs2_q;
   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign op_rd        = rd_q;
   assign op_rd_we     = rd_we_q;
   assign rf_we        = rf_we_q;
   assign rf_wr_addr   = rf_wr_addr_q;
   assign rf_wr_data   = rf_wr_data_q;
   assign busy_mask    = busy_q;
   assign stall_cycles = stall_cnt_q;
   assign wb_spurious  = spurious_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a behavioural 8-entry register file.
module tb_regfile_operand_fetch;
   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_ready, issue_rd_we;
   logic [2:0]  issue_rs1, issue_rs2, issue_rd;
   logic [2:0]  rf_rd_addr1, rf_rd_addr2;
   logic [31:0] rf_rd_data1, rf_rd_data2;
   logic        op_valid, op_ready, op_rd_we;
   logic [31:0] op_a, op_b;
   logic [2:0]  op_rd;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [31:0] wb_data;
   logic        rf_we;
   logic [2:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic [7:0]  busy_mask;
   logic [15:0] stall_cycles;
   logic        wb_spurious;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [8];
   logic [31:0] hold_a, hold_b;

   regfile_operand_fetch dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .op_rd(op_rd), .op_rd_we(op_rd_we),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .busy_mask(busy_mask), .stall_cycles(stall_cycles), .wb_spurious(wb_spurious)
   );

   always #5 clk = ~clk;

   // Register file: synchronous write, combinational read.
   always @(posedge clk) if (rf_we) mem[rf_wr_addr] <= rf_wr_data;
   assign rf_rd_data1 = mem[rf_rd_addr1];
   assign rf_rd_data2 = mem[rf_rd_addr2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] rd, input logic we);
      issue_valid = 1'b1; issue_rs1 = r1; issue_rs2 = r2; issue_rd = rd; issue_rd_we = we;
   endtask

   initial begin
      int n;
      logic [15:0] exp_stall;
`ifdef REGFILE_FETCH_FWD_BYPASS_EN
      exp_stall = 16'd3;
`else
      exp_stall = 16'd4;
`endif
      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
      mem[2] = 32'd5;
      mem[3] = 32'd7;
      reset = 1'b1; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      issue_rd_we = 1'b0; op_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      tick(); tick();
      chk("rst_issue_ready", {31'b0, issue_ready}, 32'd0);
      chk("rst_op_valid", {31'b0, op_valid}, 32'd0);
      chk("rst_busy", {24'b0, busy_mask}, 32'd0);
      chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
      @(negedge clk); reset = 1'b0; #1;
      chk("post_rst_ready", {31'b0, issue_ready}, 32'd1);

      // No hazard: op_valid two edges after acceptance.
      issue(3'd2, 3'd3, 3'd4, 1'b1);
      tick();
      issue_valid = 1'b0;
      chk("nh_read_op_valid", {31'b0, op_valid}, 32'd0);
      chk("nh_rd_addr1", {29'b0, rf_rd_addr1}, 32'd2);
      tick();
      chk("nh_op_valid", {31'b0, op_valid}, 32'd1);
      chk("nh_op_a", op_a, 32'd5);
      chk("nh_op_b", op_b, 32'd7);
      chk("nh_op_rd", {28'b0, op_rd_we, op_rd}, 32'hC);
      chk("nh_busy", {24'b0, busy_mask}, 32'h10);

      // Backpressure: HOLD is stable while op_ready is low.
      hold_a = op_a; hold_b = op_b;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_op_valid", {31'b0, op_valid}, 32'd1);
         chk("bp_op_a", op_a, hold_a);
         chk("bp_op_b", op_b, hold_b);
         chk("bp_issue_ready", {31'b0, issue_ready}, 32'd0);
      end
      op_ready = 1'b1;
      tick();
      chk("bp_release_valid", {31'b0, op_valid}, 32'd0);
      chk("bp_release_ready", {31'b0, issue_ready}, 32'd1);

      // RAW hazard on R4 resolved by a writeback two edges after acceptance.
      issue(3'd4, 3'd2, 3'd5, 1'b0);
      tick();
      issue_valid = 1'b0;
      tick();
      wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 32'hDEAD;
      tick();
      wb_valid = 1'b0;
      chk("raw_rf_we", {31'b0, rf_we}, 32'd1);
      chk("raw_wr_addr", {29'b0, rf_wr_addr}, 32'd4);
      n = 0;
      while (!op_valid && n < 20) begin tick(); n++; end
      chk("raw_op_valid_timeout", {31'b0, op_valid}, 32'd1);
      chk("raw_op_a", op_a, 32'hDEAD);
      chk("raw_op_b", op_b, 32'd5);
      chk("raw_stall_cycles", {16'b0, stall_cycles}, {16'b0, exp_stall});
      chk("raw_busy", {24'b0, busy_mask}, 32'h0);
      chk("raw_spurious", {31'b0, wb_spurious}, 32'd0);
      tick();

      // Same-edge set and clear of busy bit 1: the set wins.
      issue(3'd0, 3'd0, 3'd1, 1'b1);
      tick(); issue_valid = 1'b0;
      tick(); tick();
      chk("sc_busy_before", {24'b0, busy_mask}, 32'h02);
      chk("sc_ready", {31'b0, issue_ready}, 32'd1);
      issue(3'd0, 3'd0, 3'd1, 1'b1);
      wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 32'h11;
      tick();
      issue_valid = 1'b0; wb_valid = 1'b0;
      tick();
      chk("sc_busy_after", {24'b0, busy_mask}, 32'h02);
      chk("sc_op_valid", {31'b0, op_valid}, 32'd1);
      chk("sc_spurious", {31'b0, wb_spurious}, 32'd0);
      tick();

      // Spurious writeback to R6 with an empty scoreboard.
      wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 32'h22;
      tick(); wb_valid = 1'b0;
      tick();
      chk("sp_busy_clear", {24'b0, busy_mask}, 32'h0);
      chk("sp_before", {31'b0, wb_spurious}, 32'd0);
      wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 32'h66;
      tick(); wb_valid = 1'b0;
      chk("sp_rf_we", {31'b0, rf_we}, 32'd1);
      chk("sp_wr_addr", {29'b0, rf_wr_addr}, 32'd6);
      chk("sp_wr_data", rf_wr_data, 32'h66);
      tick();
      chk("sp_rf_we_drop", {31'b0, rf_we}, 32'd0);
      chk("sp_flag", {31'b0, wb_spurious}, 32'd1);
      tick(); tick();
      chk("sp_flag_sticky", {31'b0, wb_spurious}, 32'd1);

      // Asynchronous reset while stalled on R3.
      issue(3'd0, 3'd0, 3'd3, 1'b1);
      tick(); issue_valid = 1'b0;
      tick(); tick();
      issue(3'd3, 3'd0, 3'd7, 1'b1);
      tick(); issue_valid = 1'b0;
      tick();
      chk("mr_busy_pre", {24'b0, busy_mask}, 32'h08);
      chk("mr_ready_pre", {31'b0, issue_ready}, 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("mr_busy", {24'b0, busy_mask}, 32'h0);
      chk("mr_ready", {31'b0, issue_ready}, 32'd0);
      chk("mr_stall_cnt", {16'b0, stall_cycles}, 32'd0);
      chk("mr_spurious", {31'b0, wb_spurious}, 32'd0);
      chk("mr_rd_addr1", {29'b0, rf_rd_addr1}, 32'd0);
      chk("mr_op_rd_we", {31'b0, op_rd_we}, 32'd0);
      @(negedge clk); reset = 1'b0; #1;
      chk("mr_ready_after", {31'b0, issue_ready}, 32'd1);
      tick();
      chk("mr_idle_stays", {31'b0, issue_ready}, 32'd1);
      chk("mr_op_valid", {31'b0, op_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Requester-side controller for the 8-entry register array. It sits between the decode stage and the register file.
- Accepts decoded instructions with a valid/ready handshake and drives the two read addresses into the register file.
- Captures the operands and presents them downstream with a valid/ready handshake.
- Sequences writebacks into the register file's write port and keeps a pending-write scoreboard so no stale operand is ever issued.

Parameters:
- BITS_DATA, 32, register/operand width.
- BITS_ADDR, 3, register index width; NREGS = 2**BITS_ADDR.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- issue_valid  in  1  decoded instruction present.
- issue_ready  out  1  controller can accept an instruction.
- issue_rs1  in  BITS_ADDR  source register A.
- issue_rs2  in  BITS_ADDR  source register B.
- issue_rd  in  BITS_ADDR  destination register.
- issue_rd_we  in  1  instruction will write rd.
- rf_rd_addr1  out  BITS_ADDR  register file read address 1.
- rf_rd_addr2  out  BITS_ADDR  register file read address 2.
- rf_rd_data1  in  BITS_DATA  register file read data 1 (combinational from address).
- rf_rd_data2  in  BITS_DATA  register file read data 2 (combinational from address).
- op_valid  out  1  operands valid.
- op_ready  in  1  downstream accepts operands.
- op_a  out  BITS_DATA  operand A.
- op_b  out  BITS_DATA  operand B.
- op_rd  out  BITS_ADDR  destination register, forwarded.
- op_rd_we  out  1  destination write enable, forwarded.
- wb_valid  in  1  writeback result present; always accepted, no ready.
- wb_addr  in  BITS_ADDR  writeback register.
- wb_data  in  BITS_DATA  writeback value.
- rf_we  out  1  register file write enable.
- rf_wr_addr  out  BITS_ADDR  register file write address.
- rf_wr_data  out  BITS_DATA  register file write data.
- busy_mask  out  NREGS  scoreboard; bit i set = write to Ri pending.
- stall_cycles  out  CNT_W  saturating count of cycles spent in STALL.
- wb_spurious  out  1  sticky flag; set by a writeback to a non-busy register.

Behaviour:
- Reset values: all outputs 0, busy_mask 0, state IDLE. An assertion mid-operation discards any latched instruction, pending writeback and scoreboard.
- FSM states: IDLE, STALL, READ, HOLD.
  - issue_ready = 1 only in IDLE.
  - In IDLE, issue_valid=1 latches rs1, rs2, rd and rd_we.
    - Next state is STALL if busy_mask[rs1] or busy_mask[rs2] is set, otherwise READ.
    - Both sources are always checked.
  - STALL re-evaluates the hazard every cycle using the registered busy_mask and moves to READ once both bits are clear. stall_cycles increments by 1 per STALL cycle and saturates at all-ones.
  - READ lasts exactly one cycle. It captures rf_rd_data1/2 into op_a/op_b and goes to HOLD. If rd_we is set, it sets busy_mask[rd] at that edge.
  - HOLD: op_valid=1 and op_a, op_b, op_rd, op_rd_we stay stable. On op_ready=1 the controller returns to IDLE, with op_valid low the next cycle.
- rf_rd_addr1/2 always reflect the latched rs1/rs2; they are 0 after reset.
- Latency, no hazard: issue accepted at edge N -> op_valid high in cycle N+2. Maximum throughput is one instruction per 3 cycles with op_ready tied high.
- Writeback is registered:
  - wb_valid at edge E loads rf_we=1, rf_wr_addr and rf_wr_data for cycle E+1.
  - The register file write and the clear of busy_mask[wb_addr] both occur at edge E+1.
  - rf_we deasserts after one cycle unless a new wb_valid arrives. Back-to-back writebacks are allowed, one per cycle.
- Simultaneous set and clear of the same busy bit at one edge: the set wins, because the newer writer stays pending.
- A writeback whose register has no busy bit still writes and sets wb_spurious. wb_spurious clears only on reset.
- Without bypass, the earliest READ after a blocking write is the cycle after the clear. A hazard never lets a pre-write value reach op_a or op_b.

Optional Feature:
- Macro: REGFILE_FETCH_FWD_BYPASS_EN.
- Defined: in STALL, the hazard check masks out the bit of rf_wr_addr when rf_we=1. STALL exits to READ in the same cycle the blocking write is on the port, saving one cycle per resolved hazard. Data correctness holds because the write lands at the edge that enters READ.
- Undefined: STALL exits only once the registered busy_mask is clear.

Test Plan:
- No hazard: after reset, R2=5 and R3=7; issue rs1=2, rs2=3, rd=4, rd_we=1 at edge 0 -> op_valid in cycle 2 with op_a=5, op_b=7 and busy_mask=8'h10.
- RAW hazard: issue rd=4, consume it, then issue rs1=4; wb_valid with addr 4, data 32'hDEAD 3 cycles later -> op_a=32'hDEAD, stall_cycles=4 without the macro and 3 with it.
- Backpressure: hold op_ready=0 for 5 cycles in HOLD -> op_valid, op_a and op_b stay constant and issue_ready stays 0 throughout.
- Same-edge set/clear: an instruction with rd=1 in READ while rf_we clears bit 1 -> busy_mask[1]=1 afterwards.
- Spurious writeback: wb_valid with addr 6 while busy_mask=0 -> rf_we pulses one cycle with rf_wr_addr=6; wb_spurious=1 and stays 1.
- Reset mid-STALL: assert reset asynchronously between edges -> all outputs and busy_mask immediately 0 and state IDLE; issue_ready=1 after release.
